// File: rtl/axi4l_master.sv
// AXI4-Lite master: accepts one read or write command at a time, runs it on the
// AXI4-Lite channels and returns a single response.
// Optional watchdog: define AXI4L_MASTER_TIMEOUT_EN to abort transactions that
// stall for TIMEOUT_CYCLES cycles and to drain a late B/R response afterwards.

module axi4l_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    // response
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    // write address
    output logic [ADDR_WIDTH-1:0]   axi4l_awaddr,
    output logic [2:0]              axi4l_awprot,
    output logic                    axi4l_awvalid,
    input  logic                    axi4l_awready,
    // write data
    output logic [DATA_WIDTH-1:0]   axi4l_wdata,
    output logic [DATA_WIDTH/8-1:0] axi4l_wstrb,
    output logic                    axi4l_wvalid,
    input  logic                    axi4l_wready,
    // write response
    input  logic [1:0]              axi4l_bresp,
    input  logic                    axi4l_bvalid,
    output logic                    axi4l_bready,
    // read address
    output logic [ADDR_WIDTH-1:0]   axi4l_araddr,
    output logic [2:0]              axi4l_arprot,
    output logic                    axi4l_arvalid,
    input  logic                    axi4l_arready,
    // read data
    input  logic [DATA_WIDTH-1:0]   axi4l_rdata,
    input  logic [1:0]              axi4l_rresp,
    input  logic                    axi4l_rvalid,
    output logic                    axi4l_rready
);

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH != 32) begin : g_dw_check
        $error("axi4l_master: only DATA_WIDTH = 32 is supported");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_to_check
        $error("axi4l_master: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrResp,
        StRdAddr,
        StRdData,
        StRsp,
        StDrain
    } state_e;

    state_e                  state_q, state_d;
    logic                    run_q;
    logic                    aw_done_q, w_done_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;

    logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire, wr_done;
    logic expired;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign aw_fire  = axi4l_awvalid & axi4l_awready;
    assign w_fire   = axi4l_wvalid & axi4l_wready;
    assign b_fire   = axi4l_bvalid & axi4l_bready;
    assign ar_fire  = axi4l_arvalid & axi4l_arready;
    assign r_fire   = axi4l_rvalid & axi4l_rready;
    assign rsp_fire = rsp_valid & rsp_ready;
    // AW and W may complete in either order or together
    assign wr_done  = (aw_done_q | aw_fire) & (w_done_q | w_fire);

    assign axi4l_awaddr = addr_q;
    assign axi4l_araddr = addr_q;
    assign axi4l_wdata  = wdata_q;
    assign axi4l_wstrb  = wstrb_q;
    assign axi4l_awprot = 3'b000;
    assign axi4l_arprot = 3'b000;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;

    // Reset release is taken on the first clock edge; nothing is accepted before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

`ifdef AXI4L_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q, pend_b_q, pend_r_q;
    logic            active, abort, drain_done;

    assign active  = (state_q == StWr) | (state_q == StWrResp) |
                     (state_q == StRdAddr) | (state_q == StRdData);
    assign expired = active & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    // A handshake completing in the expiry cycle wins over the abort
    assign abort   = expired & ~((state_q == StWr) & wr_done) & ~b_fire & ~ar_fire & ~r_fire;
    assign drain_done  = (pend_b_q & b_fire) | (pend_r_q & r_fire);
    assign rsp_timeout = timeout_q;

    // Watchdog: restarts on command acceptance, counts while a transaction is on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt_q <= '0;
        else if (cmd_fire) cnt_q <= '0;
        else if (active)   cnt_q <= cnt_q + 1'b1;
    end

    // Remember a B/R still owed by the slave after an abort so it can be discarded later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_b_q <= 1'b0;
            pend_r_q <= 1'b0;
        end else if (abort) begin
            pend_b_q <= (state_q == StWrResp);
            pend_r_q <= (state_q == StRdData);
        end else if ((state_q == StDrain) && drain_done) begin
            pend_b_q <= 1'b0;
            pend_r_q <= 1'b0;
        end
    end
`else
    assign expired     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_fire) state_d = cmd_we ? StWr : StRdAddr;
            StWr: begin
                if (wr_done)      state_d = StWrResp;
                else if (expired) state_d = StRsp;
            end
            StWrResp: if (b_fire || expired) state_d = StRsp;
            StRdAddr: begin
                if (ar_fire)      state_d = StRdData;
                else if (expired) state_d = StRsp;
            end
            StRdData: if (r_fire || expired) state_d = StRsp;
            StRsp: begin
                if (rsp_fire) begin
`ifdef AXI4L_MASTER_TIMEOUT_EN
                    state_d = (pend_b_q || pend_r_q) ? StDrain : StIdle;
`else
                    state_d = StIdle;
`endif
                end
            end
            StDrain: begin
`ifdef AXI4L_MASTER_TIMEOUT_EN
                if (drain_done) state_d = StIdle;
`else
                state_d = StIdle;
`endif
            end
            default:  state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state, so no input reaches an output combinationally.
    always_comb begin
        cmd_ready     = run_q && (state_q == StIdle);
        axi4l_awvalid = (state_q == StWr) && !aw_done_q;
        axi4l_wvalid  = (state_q == StWr) && !w_done_q;
        axi4l_bready  = (state_q == StWrResp);
        axi4l_arvalid = (state_q == StRdAddr);
        axi4l_rready  = (state_q == StRdData);
        rsp_valid     = (state_q == StRsp);
`ifdef AXI4L_MASTER_TIMEOUT_EN
        if (state_q == StDrain) begin
            axi4l_bready = pend_b_q;
            axi4l_rready = pend_r_q;
        end
`endif
    end

    // Command payload capture and per-channel write handshake tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (cmd_fire) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == StWr) begin
            if (aw_fire) aw_done_q <= 1'b1;
            if (w_fire)  w_done_q  <= 1'b1;
        end
    end

    // Response capture: B, R, or a synthesised SLVERR on watchdog abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q   <= '0;
            resp_q    <= 2'b00;
`ifdef AXI4L_MASTER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else if ((state_q == StWrResp) && b_fire) begin
            rdata_q   <= '0;
            resp_q    <= axi4l_bresp;
`ifdef AXI4L_MASTER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else if ((state_q == StRdData) && r_fire) begin
            rdata_q   <= axi4l_rdata;
            resp_q    <= axi4l_rresp;
`ifdef AXI4L_MASTER_TIMEOUT_EN
            timeout_q <= 1'b0;
        end else if (abort) begin
            rdata_q   <= '0;
            resp_q    <= 2'b10;
            timeout_q <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_axi4l_master.sv
// Scoreboard bench for axi4l_master: directed commands push expected responses,
// a monitor pops and compares them, a small AXI4-Lite slave model with
// programmable per-channel delays answers the bus.

module tb_axi4l_master;

    localparam int unsigned TO    = 16;
    localparam int          NEVER = 1000;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axi4l_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .axi4l_awaddr  (awaddr),
        .axi4l_awprot  (awprot),
        .axi4l_awvalid (awvalid),
        .axi4l_awready (awready),
        .axi4l_wdata   (wdata),
        .axi4l_wstrb   (wstrb),
        .axi4l_wvalid  (wvalid),
        .axi4l_wready  (wready),
        .axi4l_bresp   (bresp),
        .axi4l_bvalid  (bvalid),
        .axi4l_bready  (bready),
        .axi4l_araddr  (araddr),
        .axi4l_arprot  (arprot),
        .axi4l_arvalid (arvalid),
        .axi4l_arready (arready),
        .axi4l_rdata   (rdata),
        .axi4l_rresp   (rresp),
        .axi4l_rvalid  (rvalid),
        .axi4l_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } rsp_t;

    rsp_t exp_q[$];
    int   tests_run = 0;
    int   fails     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // slave configuration and observation state
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          got_aw, got_w, got_ar;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int          aw_beats, w_beats, b_beats, ar_beats, r_beats;
    int          av_cyc, wv_cyc, ar_cyc, proto_err;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    bit          lat_pend, lat_we;
    bit          aw_pend, w_pend, ar_pend;
    logic [31:0] aw_prev, w_prev, ar_prev;

    // Bus observer: handshakes, payload checks, valid-hold rule, command-to-valid latency.
    always @(negedge clk) begin
        if (!rst_n) begin
            {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
            {aw_pend, w_pend, ar_pend, lat_pend} = '0;
        end else begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (awvalid) av_cyc++;
            if (wvalid)  wv_cyc++;
            if (arvalid) ar_cyc++;
            if (aw_hs) begin
                aw_beats++;
                check("awaddr", 64'(awaddr), 64'(exp_addr));
                check("awprot", 64'(awprot), 64'(0));
            end
            if (w_hs) begin
                w_beats++;
                check("wdata", 64'(wdata), 64'(exp_wdata));
                check("wstrb", 64'(wstrb), 64'(exp_wstrb));
            end
            if (b_hs) b_beats++;
            if (ar_hs) begin
                ar_beats++;
                check("araddr", 64'(araddr), 64'(exp_addr));
                check("arprot", 64'(arprot), 64'(0));
            end
            if (r_hs) r_beats++;
            // a watchdog abort is the only legal way to drop a pending valid
            if (!rsp_timeout) begin
                if (aw_pend && (!awvalid || awaddr !== aw_prev)) proto_err++;
                if (w_pend && (!wvalid || wdata !== w_prev))     proto_err++;
                if (ar_pend && (!arvalid || araddr !== ar_prev)) proto_err++;
            end
            aw_pend = awvalid && !awready;
            w_pend  = wvalid && !wready;
            ar_pend = arvalid && !arready;
            aw_prev = awaddr;
            w_prev  = wdata;
            ar_prev = araddr;
            if (lat_pend) begin
                if (lat_we) check("lat_wr_valids", 64'({awvalid, wvalid}), 64'(2'b11));
                else        check("lat_rd_arvalid", 64'(arvalid), 64'(1));
            end
            lat_pend = cmd_valid && cmd_ready;
            lat_we   = cmd_we;
        end
    end

    // Response monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h resp %0d timeout %0d, required none",
                         rsp_rdata, rsp_resp, rsp_timeout);
            end else begin
                check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
                check("rsp_resp", 64'(rsp_resp), 64'(exp_q[0].resp));
                check("rsp_timeout", 64'(rsp_timeout), 64'(exp_q[0].to));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Slave model: readies after a programmable wait, B/R after both/one address beats.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            {awready, wready, arready, bvalid, rvalid} = '0;
            {got_aw, got_w, got_ar} = '0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        end else begin
            if (awvalid) begin awready = (aw_wait >= aw_dly); aw_wait++; end
            else begin awready = 1'b0; aw_wait = 0; end
            if (wvalid) begin wready = (w_wait >= w_dly); w_wait++; end
            else begin wready = 1'b0; w_wait = 0; end
            if (arvalid) begin arready = (ar_wait >= ar_dly); ar_wait++; end
            else begin arready = 1'b0; ar_wait = 0; end
            if (b_hs) begin bvalid = 1'b0; got_aw = 0; got_w = 0; b_wait = 0; end
            if (aw_hs) got_aw = 1;
            if (w_hs)  got_w = 1;
            if (got_aw && got_w && !bvalid) begin
                if (b_wait >= b_dly) bvalid = 1'b1;
                b_wait++;
            end
            if (r_hs) begin rvalid = 1'b0; got_ar = 0; r_wait = 0; end
            if (ar_hs) got_ar = 1;
            if (got_ar && !rvalid) begin
                if (r_wait >= r_dly) rvalid = 1'b1;
                r_wait++;
            end
        end
    end

    task automatic clr_counts();
        aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0;
        av_cyc = 0; wv_cyc = 0; ar_cyc = 0; proto_err = 0;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input bit push, input logic [31:0] e_rdata,
                         input logic [1:0] e_resp, input logic e_to);
        bit ok;
        rsp_t e;
        exp_addr  = addr;
        exp_wdata = wd;
        exp_wstrb = strb;
        e.rdata = e_rdata;
        e.resp  = e_resp;
        e.to    = e_to;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_accepted", 64'(ok), 64'(1));
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_ready) begin ok = 1; break; end
        end
        check("txn_done", 64'(ok), 64'(1));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("cmd_ready_before_edge", 64'(cmd_ready), 64'(0));
        @(posedge clk); #1;
        check("cmd_ready_after_release", 64'(cmd_ready), 64'(1));
    endtask

    typedef struct {
        logic [31:0] addr, wd;
        logic [3:0]  strb;
        int          aw_d, w_d, b_d;
        logic [1:0]  bresp;
        int          av, wv;
    } wvec_t;

    typedef struct {
        logic [31:0] addr, rd;
        int          ar_d, r_d;
        logic [1:0]  rresp;
        int          stall, arc;
    } rvec_t;

    wvec_t wvecs[3];
    rvec_t rvecs[2];

    initial begin
        bit ok;
        wvecs[0] = '{32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 2'b00, 1, 1};
        wvecs[1] = '{32'h24, 32'h1234_ABCD, 4'h3, 3, 0, 1, 2'b01, 4, 1};
        wvecs[2] = '{32'h38, 32'h0BAD_F00D, 4'hC, 0, 2, 0, 2'b11, 1, 3};
        rvecs[0] = '{32'h14, 32'hDEAD_BEEF, 0, 0, 2'b10, 5, 1};
        rvecs[1] = '{32'h40, 32'h0000_5A5A, 2, 3, 2'b00, 0, 3};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b1; bresp = 2'b00; rresp = 2'b00; rdata = '0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        clr_counts();

        // reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_valids_readies", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}),
              64'(0));
        check("rst_rsp_payload", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'(0));
        release_reset();

        foreach (wvecs[i]) begin
            clr_counts();
            aw_dly = wvecs[i].aw_d; w_dly = wvecs[i].w_d; b_dly = wvecs[i].b_d;
            bresp = wvecs[i].bresp;
            issue(1'b1, wvecs[i].addr, wvecs[i].wd, wvecs[i].strb, 1'b1, 32'h0,
                  wvecs[i].bresp, 1'b0);
            wait_done();
            check("wr_aw_beats", 64'(aw_beats), 64'(1));
            check("wr_w_beats", 64'(w_beats), 64'(1));
            check("wr_b_beats", 64'(b_beats), 64'(1));
            check("wr_awvalid_cycles", 64'(av_cyc), 64'(wvecs[i].av));
            check("wr_wvalid_cycles", 64'(wv_cyc), 64'(wvecs[i].wv));
            check("wr_valid_hold", 64'(proto_err), 64'(0));
        end
        aw_dly = 0; w_dly = 0; b_dly = 0;

        foreach (rvecs[i]) begin
            clr_counts();
            ar_dly = rvecs[i].ar_d; r_dly = rvecs[i].r_d;
            rdata = rvecs[i].rd; rresp = rvecs[i].rresp;
            if (rvecs[i].stall > 0) rsp_ready = 1'b0;
            issue(1'b0, rvecs[i].addr, 32'h0, 4'h0, 1'b1, rvecs[i].rd, rvecs[i].rresp, 1'b0);
            if (rvecs[i].stall > 0) begin
                ok = 0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (rsp_valid) begin ok = 1; break; end
                end
                check("rd_rsp_seen", 64'(ok), 64'(1));
                repeat (rvecs[i].stall) @(negedge clk);
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
            wait_done();
            check("rd_ar_beats", 64'(ar_beats), 64'(1));
            check("rd_r_beats", 64'(r_beats), 64'(1));
            check("rd_arvalid_cycles", 64'(ar_cyc), 64'(rvecs[i].arc));
            check("rd_valid_hold", 64'(proto_err), 64'(0));
        end
        ar_dly = 0; r_dly = 0;

`ifdef AXI4L_MASTER_TIMEOUT_EN
        // read whose address is never accepted
        clr_counts();
        ar_dly = NEVER;
        issue(1'b0, 32'h50, 32'h0, 4'h0, 1'b1, 32'h0, 2'b10, 1'b1);
        wait_done();
        check("to_arvalid_cycles", 64'(ar_cyc), 64'(TO));
        check("to_ar_beats", 64'(ar_beats), 64'(0));
        ar_dly = 0;

        // write whose B arrives long after the abort; it must be drained silently
        clr_counts();
        b_dly = 25; bresp = 2'b00;
        issue(1'b1, 32'h60, 32'h7777_1111, 4'hF, 1'b1, 32'h0, 2'b10, 1'b1);
        wait_done();
        check("drain_b_beats", 64'(b_beats), 64'(1));
        check("drain_bvalid_gone", 64'(bvalid), 64'(0));
        b_dly = 0;
        clr_counts();
        rdata = 32'h600D_CAFE; rresp = 2'b00;
        issue(1'b0, 32'h64, 32'h0, 4'h0, 1'b1, 32'h600D_CAFE, 2'b00, 1'b0);
        wait_done();
        check("post_drain_r_beats", 64'(r_beats), 64'(1));
`endif

        // reset while waiting for read data
        clr_counts();
        r_dly = NEVER;
        issue(1'b0, 32'h70, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00, 1'b0);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rready) begin ok = 1; break; end
        end
        check("rst_reached_rd_data", 64'(ok), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_arvalid", 64'(arvalid), 64'(0));
        check("rst_mid_rready", 64'(rready), 64'(0));
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'(0));
        repeat (2) @(posedge clk);
        r_dly = 0;
        release_reset();
        rdata = 32'h0F0F_0F0F; rresp = 2'b01;
        issue(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 32'h0F0F_0F0F, 2'b01, 1'b0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
